rst_seq: RTL and testbench
==========================

RST_SEQ -- requirements
Module: rst_seq

Interface
REQ-001 SHALL have parameter N_CH, default 4: number of sequenced reset channels, legal range 2..16.
REQ-002 SHALL have parameter HOLD_CYC, default 4: default cycles per stage, legal range 1..2^CNT_W-1.
REQ-003 SHALL have parameter CNT_W, default 8: width of the hold counter and of hold_cnt.
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port lock  input  1  clock-source locked; must be synchronous to clk.
REQ-007 SHALL have port sw_rst  input  1  software reset request, level-sensitive, synchronous.
REQ-008 SHALL have port hold_cnt  input  CNT_W  runtime cycles per stage; 0 selects HOLD_CYC.
REQ-009 SHALL have port rst_out  output  N_CH  per-channel reset, active-high; bit 0 releases first.
REQ-010 SHALL have port done  output  1  high when all channels are released.
REQ-011 SHALL have port stage  output  max(1,clog2(N_CH))  index of the channel currently being timed.

Function
REQ-012 SHALL implement the states WAIT_LOCK, HOLD and DONE.
REQ-013 In WAIT_LOCK, with lock=1 and sw_rst=0 at a rising edge, the block SHALL go to HOLD at that edge.
REQ-014 On that WAIT_LOCK->HOLD edge, the block SHALL latch H = (hold_cnt==0 ? HOLD_CYC : hold_cnt), load the counter with H-1 and set stage=0.
REQ-015 The latched H SHALL apply to all stages; hold_cnt changes during HOLD or DONE SHALL have no effect until the next WAIT_LOCK exit.
REQ-016 In HOLD with counter != 0, the block SHALL decrement the counter by 1 per cycle.
REQ-017 In HOLD with counter == 0 and stage < N_CH-1, the block SHALL clear rst_out[stage], increment stage and reload the counter with H-1.
REQ-018 In HOLD with counter == 0 and stage == N_CH-1, the block SHALL clear rst_out[stage], set done=1 on the same edge and go to DONE; stage SHALL hold at N_CH-1.
REQ-019 Timing: rst_out[i] SHALL fall exactly (i+1)*H rising edges after the edge that samples lock high; done SHALL rise on the same edge as rst_out[N_CH-1].
REQ-020 With H=1, the block SHALL release one channel per cycle with no gap.
REQ-021 Once cleared, a rst_out bit SHALL stay low until an abort (REQ-022) or rst; no bit SHALL ever re-assert individually.
REQ-022 Abort: in HOLD or DONE, lock=0 or sw_rst=1 at an edge SHALL, on that edge, set rst_out to all ones, done=0, stage=0, counter=0, and go to WAIT_LOCK.
REQ-023 In WAIT_LOCK, sw_rst=1 SHALL take priority over lock=1; the block SHALL stay in WAIT_LOCK while sw_rst is high.
REQ-024 Abort SHALL take priority over a release scheduled on the same edge, so no channel is released on an abort edge.
REQ-025 The block SHALL restart from stage 0 after every abort; partial progress SHALL NOT be retained.
REQ-026 The counter SHALL never wrap: it is only decremented when non-zero.

Reset
REQ-027 While rst=1, the block SHALL asynchronously force state=WAIT_LOCK, rst_out={N_CH{1}}, done=0, stage=0, counter=0 and H=HOLD_CYC.
REQ-028 After rst deasserts, the block SHALL leave WAIT_LOCK no earlier than the first rising edge that samples lock=1 and sw_rst=0.
REQ-029 rst asserted mid-sequence SHALL immediately reassert all rst_out bits without waiting for a clock edge.

Verification
REQ-030 Defaults (N_CH=4, HOLD_CYC=4), hold_cnt=0, lock rises at edge k -> rst_out goes 1111->1110 @k+4, 1100 @k+8, 1000 @k+12, 0000 @k+16; done=1 @k+16.
REQ-031 hold_cnt=1 -> rst_out bits clear on 4 consecutive edges k+1..k+4; done @k+4; hold_cnt=7 -> releases at k+7, k+14, k+21, k+28.
REQ-032 lock drops for 1 cycle while stage=2 -> rst_out=1111, done=0 on the next edge; after lock returns, the full sequence repeats with the original timing.
REQ-033 sw_rst pulse in DONE -> all ones on the next edge; sw_rst held high with lock=1 -> the block stays in WAIT_LOCK until sw_rst falls.
REQ-034 Abort coincident with a scheduled release (counter==0) -> that channel is not released and rst_out=1111.
REQ-035 rst asserted between clock edges mid-HOLD -> rst_out=1111 before the next edge; hold_cnt changed mid-HOLD -> no effect on the current sequence's timing.

Source files
------------

// File: rtl/rst_seq.sv
// rtl/rst_seq.sv - staged reset release sequencer gated by clock lock.
// Channels leave reset one at a time, bit 0 first, each after H cycles.
module rst_seq #(
  parameter int N_CH     = 4,
  parameter int HOLD_CYC = 4,
  parameter int CNT_W    = 8,
  localparam int SW      = ($clog2(N_CH) < 1) ? 1 : $clog2(N_CH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             lock,
  input  logic             sw_rst,
  input  logic [CNT_W-1:0] hold_cnt,
  output logic [N_CH-1:0]  rst_out,
  output logic             done,
  output logic [SW-1:0]    stage
);

  localparam logic [1:0] WAIT_LOCK = 2'd0;
  localparam logic [1:0] HOLD      = 2'd1;
  localparam logic [1:0] DONE      = 2'd2;

  localparam logic [SW-1:0]    LAST  = SW'(N_CH - 1);
  localparam logic [CNT_W-1:0] H_DEF = CNT_W'(HOLD_CYC);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] h_q;
  logic [CNT_W-1:0] h_sel;
  logic             abort;

  assign h_sel = (hold_cnt == '0) ? H_DEF : hold_cnt;
  assign abort = !lock || sw_rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= WAIT_LOCK;
      rst_out <= '1;
      done    <= 1'b0;
      stage   <= '0;
      cnt     <= '0;
      h_q     <= H_DEF;
    end else begin
      case (state)
        WAIT_LOCK: begin
          // sw_rst outranks lock; the stage length is frozen here for the whole run
          if (lock && !sw_rst) begin
            state <= HOLD;
            h_q   <= h_sel;
            cnt   <= h_sel - ONE;
            stage <= '0;
          end
        end
        HOLD: begin
          if (abort) begin
            state   <= WAIT_LOCK;
            rst_out <= '1;
            done    <= 1'b0;
            stage   <= '0;
            cnt     <= '0;
          end else if (cnt != '0) begin
            cnt <= cnt - ONE;
          end else begin
            rst_out[stage] <= 1'b0;
            if (stage == LAST) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              stage <= stage + SW'(1);
              cnt   <= h_q - ONE;
            end
          end
        end
        DONE: begin
          if (abort) begin
            state   <= WAIT_LOCK;
            rst_out <= '1;
            done    <= 1'b0;
            stage   <= '0;
            cnt     <= '0;
          end
        end
        default: begin
          state   <= WAIT_LOCK;
          rst_out <= '1;
          done    <= 1'b0;
          stage   <= '0;
          cnt     <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rst_seq.sv
// tb/tb_rst_seq.sv - self-checking bench for rst_seq.
module tb_rst_seq;

  typedef struct {
    logic [3:0] ro;
    logic       dn;
    logic [1:0] st;
  } exp_t;

  typedef struct {
    logic [7:0] hc;
    logic [7:0] hc_mid;
    int         h;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       lock;
  logic       sw_rst;
  logic [7:0] hold_cnt;
  logic [3:0] rst_out;
  logic       done;
  logic [1:0] stage;

  int   nrun  = 0;
  int   nfail = 0;
  exp_t sbq[$];
  vec_t vt[4];

  always #5 clk = ~clk;

  rst_seq dut (
    .clk      (clk),
    .rst      (rst),
    .lock     (lock),
    .sw_rst   (sw_rst),
    .hold_cnt (hold_cnt),
    .rst_out  (rst_out),
    .done     (done),
    .stage    (stage)
  );

  // n = rising edges since the edge that sampled lock high
  function automatic exp_t model(int n, int h);
    exp_t e;
    for (int i = 0; i < 4; i++) e.ro[i] = (n < (i + 1) * h);
    e.dn = (n >= 4 * h);
    e.st = ((n / h) > 3) ? 2'd3 : 2'(n / h);
    return e;
  endfunction

  function automatic exp_t all_ones();
    exp_t e;
    e.ro = 4'hf;
    e.dn = 1'b0;
    e.st = 2'd0;
    return e;
  endfunction

  task automatic cmp(string nm, logic [3:0] act, logic [3:0] req);
    nrun++;
    if (act !== req) begin
      nfail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, req, $time);
    end
  endtask

  task automatic step(string nm);
    exp_t e;
    @(posedge clk);
    #2;
    if (sbq.size() == 0) begin
      nrun++;
      nfail++;
      $display("FAIL %s: scoreboard empty", nm);
    end else begin
      e = sbq.pop_front();
      cmp({nm, ".rst_out"}, rst_out, e.ro);
      cmp({nm, ".done"}, {3'b0, done}, {3'b0, e.dn});
      cmp({nm, ".stage"}, {2'b0, stage}, {2'b0, e.st});
    end
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    lock     = 1'b0;
    sw_rst   = 1'b0;
    hold_cnt = 8'd0;
    #1;
    cmp("reset.rst_out", rst_out, 4'hf);
    cmp("reset.done", {3'b0, done}, 4'h0);
    cmp("reset.stage", {2'b0, stage}, 4'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    // no lock yet: must stay in WAIT_LOCK
    for (int i = 0; i < 2; i++) begin
      sbq.push_back(all_ones());
      step("idle");
    end
  endtask

  // raise lock and follow the sequence up to edge n_last after the lock edge
  task automatic run_seq(string nm, int h, int n_last, logic [7:0] hc_mid);
    lock   = 1'b1;
    sw_rst = 1'b0;
    for (int n = 0; n <= n_last; n++) begin
      sbq.push_back(model(n, h));
      step(nm);
      if (n == 0) hold_cnt = hc_mid;
    end
  endtask

  initial begin
    vt[0] = '{8'd0, 8'd5, 4};
    vt[1] = '{8'd1, 8'd0, 1};
    vt[2] = '{8'd7, 8'd3, 7};
    vt[3] = '{8'd2, 8'd9, 2};

    for (int v = 0; v < 4; v++) begin
      do_reset();
      hold_cnt = vt[v].hc;
      run_seq($sformatf("vec%0d", v), vt[v].h, 4 * vt[v].h + 2, vt[v].hc_mid);
    end

    // lock drop at stage 2, then a full clean restart
    do_reset();
    run_seq("pre_drop", 4, 9, 8'd0);
    lock = 1'b0;
    sbq.push_back(all_ones());
    step("lock_drop");
    run_seq("after_drop", 4, 17, 8'd0);

    // sw_rst in DONE, then held high with lock high
    sw_rst = 1'b1;
    sbq.push_back(all_ones());
    step("sw_rst_done");
    for (int i = 0; i < 4; i++) begin
      sbq.push_back(all_ones());
      step("sw_rst_held");
    end
    run_seq("after_sw", 4, 5, 8'd0);

    // abort on the edge a release was due
    do_reset();
    run_seq("pre_coinc", 4, 3, 8'd0);
    lock = 1'b0;
    sbq.push_back(all_ones());
    step("abort_coinc");

    // asynchronous rst mid-HOLD
    do_reset();
    run_seq("pre_async", 4, 9, 8'd0);
    #3;
    rst = 1'b1;
    #1;
    cmp("async_rst.rst_out", rst_out, 4'hf);
    cmp("async_rst.done", {3'b0, done}, 4'h0);
    @(negedge clk);
    rst = 1'b0;

    if (sbq.size() != 0) begin
      nrun++;
      nfail++;
      $display("FAIL scoreboard_leftover: got %0d expected 0", sbq.size());
    end
    $display("[TB] %0d tests run, %0d failed", nrun, nfail);
    $finish;
  end

endmodule
